// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit.
// Contents: B-type funct3 codes, 2-bit BHT counter encoding and reset
// value, and the saturating counter update helper.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bhtState_e;

    localparam bhtState_e BHT_RESET = WNT;

    // Saturating 2-bit counter step: taken counts up to ST, not-taken down to SNT.
    function automatic bhtState_e satUpdate(input bhtState_e cur, input logic taken);
        bhtState_e nxt;
        nxt = cur;
        case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = BHT_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch-compare and redirect bundle between execute/fetch (master) and
// the branch resolve unit (slave).
// Ports (slave view):
//   in : br_valid, br_funct3, br_pc, br_target, br_pred_taken, BrEq, BrLT, redirect_ready
//   out: BrUn, br_stall, br_taken, illegal_br, redirect_valid, redirect_pc
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            br_valid;
    logic [2:0]      br_funct3;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_target;
    logic            br_pred_taken;
    logic            BrUn;
    logic            BrEq;
    logic            BrLT;
    logic            br_stall;
    logic            br_taken;
    logic            illegal_br;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output br_valid, br_funct3, br_pc, br_target, br_pred_taken, BrEq, BrLT, redirect_ready,
        input  BrUn, br_stall, br_taken, illegal_br, redirect_valid, redirect_pc
    );

    modport slave (
        input  br_valid, br_funct3, br_pc, br_target, br_pred_taken, BrEq, BrLT, redirect_ready,
        output BrUn, br_stall, br_taken, illegal_br, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// Ports:
//   clk, rst            clock, synchronous active-high reset (all entries -> WNT)
//   rdIdx / rdState     asynchronous read port
//   updEn/updIdx/updTaken  synchronous update port; counter saturates internally
module bht_2bit
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(ENTRIES)-1:0] rdIdx,
    output bhtState_e                  rdState,
    input  logic                       updEn,
    input  logic [$clog2(ENTRIES)-1:0] updIdx,
    input  logic                       updTaken
);

    bhtState_e counters [ENTRIES];

    // Read sees the stored value, so a same-cycle update is not visible until the next edge.
    assign rdState = counters[rdIdx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= BHT_RESET;
            end
        end else if (updEn) begin
            counters[updIdx] <= satUpdate(counters[updIdx], updTaken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decodes B-type funct3, resolves direction from the
// comparator flags, checks it against the fetch-time prediction, issues a
// registered PC redirect on mispredict and trains the BHT.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   fetch_pc       fetch lookup PC
//   pred_taken     combinational BHT prediction for fetch_pc
//   brIf           branch/comparator/redirect bundle (slave side)
//   branch_cnt     accepted branches
//   mispred_cnt    accepted mispredicted branches
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    branch_resolve_unit_if.slave brIf,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic      rawTaken;
    logic      isIllegal;
    logic      accept;
    logic      mispredict;
    bhtState_e fetchState;

    always_comb begin
        rawTaken  = 1'b0;
        isIllegal = 1'b0;
        case (brIf.br_funct3)
            F3_BEQ:           rawTaken = brIf.BrEq;
            F3_BNE:           rawTaken = !brIf.BrEq;
            F3_BLT, F3_BLTU:  rawTaken = brIf.BrLT;
            F3_BGE, F3_BGEU:  rawTaken = !brIf.BrLT;
            default:          isIllegal = 1'b1;
        endcase
    end

    assign brIf.BrUn = brIf.br_funct3[2] & brIf.br_funct3[1];

    // A completing handshake frees the slot in the same cycle, so a held
    // branch can be accepted while the old redirect is being consumed.
    assign brIf.br_stall = brIf.redirect_valid & !brIf.redirect_ready;
    assign accept        = brIf.br_valid & !brIf.br_stall;
    assign brIf.br_taken = accept & rawTaken;
    assign mispredict    = accept & (rawTaken != brIf.br_pred_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            brIf.redirect_valid <= 1'b0;
            brIf.redirect_pc    <= '0;
            brIf.illegal_br     <= 1'b0;
            branch_cnt          <= '0;
            mispred_cnt         <= '0;
        end else begin
            brIf.illegal_br <= accept & isIllegal;
            if (accept) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispredict) begin
                mispred_cnt         <= mispred_cnt + CNT_W'(1);
                brIf.redirect_valid <= 1'b1;
                brIf.redirect_pc    <= rawTaken ? brIf.br_target : brIf.br_pc + XLEN'(4);
            end else if (brIf.redirect_valid && brIf.redirect_ready) begin
                brIf.redirect_valid <= 1'b0;
            end
        end
    end

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rdIdx    (fetch_pc[IDX_W+1:2]),
        .rdState  (fetchState),
        .updEn    (accept & !isIllegal),
        .updIdx   (brIf.br_pc[IDX_W+1:2]),
        .updTaken (rawTaken)
    );

    assign pred_taken = fetchState[1];

    logic unusedBits;
    assign unusedBits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0], fetchState[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit_if #(.XLEN(32)) brBus ();

    branch_resolve_unit #(
        .XLEN        (32),
        .BHT_ENTRIES (64),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_pc    (fetch_pc),
        .pred_taken  (pred_taken),
        .brIf        (brBus),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are then changed and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setBr(input logic v, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred, input logic eq, input logic lt);
        brBus.br_valid      = v;
        brBus.br_funct3     = f3;
        brBus.br_pc         = pc;
        brBus.br_target     = tgt;
        brBus.br_pred_taken = pred;
        brBus.BrEq          = eq;
        brBus.BrLT          = lt;
        #1;
    endtask

    task automatic idle();
        brBus.br_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b1;
        fetch_pc             = 32'h0;
        brBus.redirect_ready = 1'b0;
        setBr(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // 1: reset state
        fetch_pc = 32'h100;
        #1;
        checkVal("rst_pred", pred_taken, 1'b0);
        checkVal("rst_bcnt", branch_cnt, 32'd0);
        checkVal("rst_mcnt", mispred_cnt, 32'd0);
        checkVal("rst_rvalid", brBus.redirect_valid, 1'b0);
        checkVal("rst_rpc", brBus.redirect_pc, 32'h0);
        checkVal("rst_illegal", brBus.illegal_br, 1'b0);

        // 2: BEQ taken, predicted not-taken
        fetch_pc = 32'h200;
        setBr(1'b1, 3'b000, 32'h200, 32'h240, 1'b0, 1'b1, 1'b0);
        checkVal("beq_taken", brBus.br_taken, 1'b1);
        checkVal("beq_brun", brBus.BrUn, 1'b0);
        checkVal("beq_stall", brBus.br_stall, 1'b0);
        checkVal("beq_pred_rbw", pred_taken, 1'b0);
        tick();
        idle();
        checkVal("beq_rvalid", brBus.redirect_valid, 1'b1);
        checkVal("beq_rpc", brBus.redirect_pc, 32'h240);
        checkVal("beq_mcnt", mispred_cnt, 32'd1);
        checkVal("beq_bcnt", branch_cnt, 32'd1);
        checkVal("beq_bht", pred_taken, 1'b1);
        brBus.redirect_ready = 1'b1;
        #1;
        checkVal("hs_nostall", brBus.br_stall, 1'b0);
        tick();
        brBus.redirect_ready = 1'b0;
        #1;
        checkVal("hs_clear", brBus.redirect_valid, 1'b0);

        // 3: BLTU taken as predicted; BGE taken as predicted
        setBr(1'b1, 3'b110, 32'h304, 32'h380, 1'b1, 1'b0, 1'b1);
        checkVal("bltu_brun", brBus.BrUn, 1'b1);
        checkVal("bltu_taken", brBus.br_taken, 1'b1);
        tick();
        setBr(1'b1, 3'b101, 32'h308, 32'h390, 1'b1, 1'b0, 1'b0);
        checkVal("bltu_rvalid", brBus.redirect_valid, 1'b0);
        checkVal("bltu_bcnt", branch_cnt, 32'd2);
        checkVal("bge_brun", brBus.BrUn, 1'b0);
        checkVal("bge_taken", brBus.br_taken, 1'b1);
        tick();
        idle();
        checkVal("bge_bcnt", branch_cnt, 32'd3);
        checkVal("bge_mcnt", mispred_cnt, 32'd1);
        checkVal("bge_rvalid", brBus.redirect_valid, 1'b0);

        // 4: redirect held under back-pressure, held branch accepted on ready
        setBr(1'b1, 3'b001, 32'h40C, 32'h480, 1'b0, 1'b0, 1'b0);
        tick();
        setBr(1'b1, 3'b000, 32'h510, 32'h520, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkVal("bp_stall", brBus.br_stall, 1'b1);
            checkVal("bp_taken", brBus.br_taken, 1'b0);
            checkVal("bp_rvalid", brBus.redirect_valid, 1'b1);
            checkVal("bp_rpc", brBus.redirect_pc, 32'h480);
            checkVal("bp_bcnt", branch_cnt, 32'd4);
            tick();
        end
        brBus.redirect_ready = 1'b1;
        #1;
        checkVal("bp_release", brBus.br_stall, 1'b0);
        tick();
        idle();
        checkVal("bp_new_rvalid", brBus.redirect_valid, 1'b1);
        checkVal("bp_new_rpc", brBus.redirect_pc, 32'h514);
        checkVal("bp_bcnt2", branch_cnt, 32'd5);
        checkVal("bp_mcnt", mispred_cnt, 32'd3);
        tick();
        brBus.redirect_ready = 1'b0;
        #1;
        checkVal("bp_done", brBus.redirect_valid, 1'b0);

        // 5: saturation at index of 0xA0
        fetch_pc = 32'hA0;
        for (int i = 0; i < 4; i++) begin
            setBr(1'b1, 3'b000, 32'hA0, 32'hC0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        idle();
        checkVal("sat_up", pred_taken, 1'b1);
        setBr(1'b1, 3'b000, 32'hA0, 32'hC0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checkVal("sat_st_to_wt", pred_taken, 1'b1);
        setBr(1'b1, 3'b000, 32'hA0, 32'hC0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checkVal("sat_wt_to_wnt", pred_taken, 1'b0);
        for (int i = 0; i < 3; i++) begin
            setBr(1'b1, 3'b000, 32'hA0, 32'hC0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        setBr(1'b1, 3'b000, 32'hA0, 32'hC0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        checkVal("sat_floor", pred_taken, 1'b0);
        checkVal("sat_rvalid", brBus.redirect_valid, 1'b0);

        // illegal funct3 with pred=0: pulse, no redirect, BHT untouched (stays 01)
        setBr(1'b1, 3'b010, 32'hA0, 32'hC0, 1'b0, 1'b1, 1'b1);
        checkVal("ill_taken", brBus.br_taken, 1'b0);
        tick();
        idle();
        checkVal("ill_pulse", brBus.illegal_br, 1'b1);
        checkVal("ill_rvalid", brBus.redirect_valid, 1'b0);
        tick();
        checkVal("ill_pulse_end", brBus.illegal_br, 1'b0);
        setBr(1'b1, 3'b000, 32'hA0, 32'hC0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        checkVal("ill_bht_kept", pred_taken, 1'b1);

        // illegal funct3 with pred=1: redirect to pc+4
        setBr(1'b1, 3'b011, 32'hB0, 32'hF0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checkVal("ill_pred_rvalid", brBus.redirect_valid, 1'b1);
        checkVal("ill_pred_rpc", brBus.redirect_pc, 32'hB4);
        checkVal("ill_pred_pulse", brBus.illegal_br, 1'b1);

        // 6: reset mid-handshake
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkVal("rst2_rvalid", brBus.redirect_valid, 1'b0);
        checkVal("rst2_bcnt", branch_cnt, 32'd0);
        checkVal("rst2_mcnt", mispred_cnt, 32'd0);
        checkVal("rst2_bht", pred_taken, 1'b0);
        setBr(1'b1, 3'b000, 32'h600, 32'h640, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        checkVal("rst2_rpc", brBus.redirect_pc, 32'h640);
        brBus.redirect_ready = 1'b1;
        tick();
        brBus.redirect_ready = 1'b0;
        setBr(1'b1, 3'b001, 32'hFFFFFFFC, 32'h10, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        checkVal("wrap_rvalid", brBus.redirect_valid, 1'b1);
        checkVal("wrap_rpc", brBus.redirect_pc, 32'h0);
        checkVal("wrap_mcnt", mispred_cnt, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
